dcache_assoc: RTL and testbench
===============================

# dcache_assoc

Parametrised set-associative write-back, write-allocate data cache between the pipeline memory stage and the block-wide data memory. It generalises the direct-mapped data cache in three ways:
- configurable ways, sets and block size;
- true-LRU replacement;
- byte-enable writes.

Hits complete with no stall. Misses stall the pipeline through `busywait` while dirty victims are written back and the block is refilled.

## Interface
Parameters:
- `WAYS`, 2, associativity; power of two, 1..8.
- `SETS`, 8, number of sets; power of two, ≥2.
- `WORDS`, 4, 32-bit words per block; power of two, ≥2.
- Derived widths:
  - `OFF_W=clog2(WORDS)`
  - `IDX_W=clog2(SETS)`
  - `TAG_W=30-OFF_W-IDX_W`
  - `BLK_W=32*WORDS`
  - `MA_W=30-OFF_W`

Ports:
- `CLOCK` in 1: single clock. All state updates on its falling edge.
- `RESET` in 1: synchronous, active-high; sampled on the falling edge of `CLOCK`.
- `READ_EN` in 1: load request.
- `WRITE_EN` in 1: store request. Takes precedence if both enables are high.
- `address` in 32: byte address. Bits [1:0] are ignored.
- `WRITE_DATA` in 32: store data.
- `BYTE_EN` in 4: store byte lanes; bit i selects byte i.
- `READ_DATA` out 32: hit word, combinational. 0 when there is no hit.
- `busywait` out 1: stall pipeline.
- `mem_read` out 1: memory block read request.
- `mem_write` out 1: memory block write request.
- `mem_address` out `MA_W`: block address.
- `mem_WRITE_DATA` out `BLK_W`: victim block. Word 0 sits in the LSBs.
- `mem_READ_DATA` in `BLK_W`: refill block.
- `mem_busywait` in 1: memory busy. Its high-to-low transition completes the transaction.

## Operation
Address fields:
- tag = `address[31:2+OFF_W+IDX_W]`
- index = `address[2+OFF_W+IDX_W-1:2+OFF_W]`
- offset = `address[2+OFF_W-1:2]`

Per line state: valid, dirty, tag, and `WORDS` data words. Per set: a `clog2(WAYS)`-bit age for each way, with 0 meaning most recent.

Hit rule:
- Hit = request active and some way in the set is valid with a matching tag. At most one way may match.
- Read hit: `READ_DATA` is the selected word; `busywait` is 0.
- Write hit: selected bytes are merged at the next edge and dirty is set. If `BYTE_EN`=0, data and dirty are unchanged.
- Every hit updates LRU: the accessed way's age becomes 0; ways younger than its old age increment by 1.

Victim selection: the lowest-numbered invalid way; otherwise the way with age `WAYS-1`.

FSM states: IDLE, WRITEBACK, FETCH, REFILL.
- IDLE:
  - Miss with a dirty victim → WRITEBACK. Miss with a clean or invalid victim → FETCH.
  - On leaving IDLE, latch tag, index, offset, victim way, `WRITE_EN`, `WRITE_DATA` and `BYTE_EN`. All later states use only the latched copies.
- WRITEBACK:
  - `mem_write`=1, `mem_address`={victim tag, index}, `mem_WRITE_DATA`=victim block.
  - Leaves to FETCH on the edge where `mem_busywait`=0.
- FETCH:
  - `mem_read`=1, `mem_address`={latched tag, index}.
  - Leaves to REFILL on the edge where `mem_busywait`=0.
- REFILL:
  - Install `mem_READ_DATA` into the victim way and set the tag and valid.
  - Latched write: merge the store bytes into the installed block and set dirty=1. Latched read: dirty=0.
  - Update LRU for the victim way, then → IDLE.
  - The request re-evaluates in IDLE and now hits.
- `busywait`=1 in every state other than IDLE, and also combinationally in IDLE when a request misses.

## Timing
Reset values:
- valid=0, dirty=0 for all lines; age of way i = i; state=IDLE.
- `busywait`, `mem_read`, `mem_write` = 0; `mem_address`, `mem_WRITE_DATA` = 0.
- Tags and data are not reset.

Latency:
- Hit: 0 stall cycles.
- Clean miss: FETCH cycles (memory latency) + 1 REFILL cycle + the hit cycle.
- Dirty miss: adds the WRITEBACK cycles.

Handshake: `mem_read` and `mem_write` are never high together. Each is held steady until memory completes.

Boundary conditions:
- Enables deasserted mid-miss: the transaction still completes and refills; `busywait` drops in IDLE.
- `address` changes mid-miss: ignored, because the latched copy is used.
- `RESET` mid-miss: next edge forces IDLE, drops memory requests and invalidates all lines.
- `WAYS`=1: degenerates to a direct-mapped cache with no age state.

## Structure
- Package `dcache_pkg`: FSM state encoding, clog2 function, derived-width constants.
- Sub-module `dcache_lru`: per-set age array. Inputs are index, accessed way and update strobe; outputs are the victim way. Reset initialises ages.
- Top level: tag compare, byte merge, FSM.

## Test plan
Configuration WAYS=2, SETS=8, WORDS=4; memory latency 5 cycles.
- Reset, then read `0x0000_0040`: FETCH with `mem_address`=`0x0000004`; REFILL; `READ_DATA`=word 0 of the block; `busywait` high for 7 cycles.
- Write `0x0000_0044`, data `0xAABBCCDD`, `BYTE_EN`=`0011` on a hit → no stall. A following read returns the old upper half with `CCDD` in the low bytes; the line is dirty.
- Fill set 4 with tags A and B, touch A, then miss on tag C → the B way (LRU) is replaced. A later read of A hits.
- Victim dirty on a miss → WRITEBACK with the correct victim address and block, then FETCH; memory holds the written data afterwards.
- Write miss with `BYTE_EN`=`1111` → refilled line holds `WRITE_DATA` in the offset word and memory data elsewhere; dirty=1.
- Assert `RESET` during FETCH → `mem_read` falls at the next edge, `busywait`=0, and a re-read misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the set-associative data cache.
// Holds the FSM encoding, width helpers and the byte-lane merge function.
package dcache_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FETCH,
    S_REFILL
  } dc_state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Way index width; kept at 1 bit so WAYS=1 still has a legal vector.
  function automatic int way_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: per-set true-LRU age array (0 = most recent).
// Ports: i_clk/i_rst, i_upd strobe, i_idx set, i_way accessed way, o_victim oldest way.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 8,
  localparam int IDX_W = clog2(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_upd,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAY_W-1:0] i_way,
  output logic [WAY_W-1:0] o_victim
);
  if (WAYS > 1) begin : g_age
    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic [WAY_W-1:0] w_old;

    assign w_old = r_age[i_idx][i_way];

    always_ff @(negedge i_clk) begin
      if (i_rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            r_age[s][w] <= WAY_W'(w);
      end else if (i_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == i_way)
            r_age[i_idx][w] <= '0;
          else if (r_age[i_idx][w] < w_old)
            r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
        end
      end
    end

    always_comb begin
      o_victim = '0;
      for (int w = 0; w < WAYS; w++)
        if (r_age[i_idx][w] == WAY_W'(WAYS - 1))
          o_victim = WAY_W'(w);
    end
  end else begin : g_none
    logic w_unused;
    assign w_unused = i_clk ^ i_rst ^ i_upd ^ (^i_idx) ^ (^i_way);
    assign o_victim = '0;
  end
endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative write-back, write-allocate data cache.
// Ports: CPU side (READ_EN/WRITE_EN/address/WRITE_DATA/BYTE_EN/READ_DATA/busywait), block memory side (mem_*).
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 8,
  parameter  int WORDS = 4,
  localparam int OFF_W = clog2(WORDS),
  localparam int IDX_W = clog2(SETS),
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W,
  localparam int BLK_W = WORD_W * WORDS,
  localparam int MA_W  = ADDR_W - 2 - OFF_W,
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             READ_EN,
  input  logic             WRITE_EN,
  input  logic [31:0]      address,
  input  logic [31:0]      WRITE_DATA,
  input  logic [3:0]       BYTE_EN,
  output logic [31:0]      READ_DATA,
  output logic             busywait,
  output logic             mem_read,
  output logic             mem_write,
  output logic [MA_W-1:0]  mem_address,
  output logic [BLK_W-1:0] mem_WRITE_DATA,
  input  logic [BLK_W-1:0] mem_READ_DATA,
  input  logic             mem_busywait
);
  logic [SETS-1:0]  r_valid [WAYS];
  logic [SETS-1:0]  r_dirty [WAYS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [BLK_W-1:0] r_data  [WAYS][SETS];

  dc_state_e        r_state, w_next;
  logic [TAG_W-1:0] r_ltag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic [WAY_W-1:0] r_way;
  logic             r_wr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_req, w_match, w_hit, w_refill;
  logic [WAY_W-1:0] w_hway, w_lru, w_vic;
  logic [BLK_W-1:0] w_fill;
  logic             w_unused;

  assign w_tag    = address[31 -: TAG_W];
  assign w_idx    = address[2+OFF_W +: IDX_W];
  assign w_off    = address[2 +: OFF_W];
  assign w_unused = ^address[1:0];
  assign w_req    = READ_EN | WRITE_EN;
  assign w_refill = (r_state == S_REFILL);

  always_comb begin
    w_match = 1'b0;
    w_hway  = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_match = 1'b1;
        w_hway  = WAY_W'(w);
      end
  end

  assign w_hit = (r_state == S_IDLE) & w_req & w_match;
  assign READ_DATA = w_hit ?
    r_data[w_hway][w_idx][int'(w_off)*32 +: 32] : 32'd0;

  // The age array follows the live index in IDLE and the latched one in REFILL.
  dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .i_clk    (CLOCK),
    .i_rst    (RESET),
    .i_upd    (w_hit | w_refill),
    .i_idx    (w_refill ? r_idx : w_idx),
    .i_way    (w_refill ? r_way : w_hway),
    .o_victim (w_lru)
  );

  // Lowest invalid way wins over the LRU way.
  always_comb begin
    w_vic = w_lru;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w][w_idx]) w_vic = WAY_W'(w);
  end

  always_comb begin
    w_fill = mem_READ_DATA;
    if (r_wr)
      w_fill[int'(r_off)*32 +: 32] = byte_merge(
        mem_READ_DATA[int'(r_off)*32 +: 32], r_wdata, r_be);
  end

  always_comb begin
    w_next         = r_state;
    busywait       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_WRITE_DATA = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && !w_match) begin
          busywait = 1'b1;
          if (r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx])
            w_next = S_WB;
          else
            w_next = S_FETCH;
        end
      end
      S_WB: begin
        busywait       = 1'b1;
        mem_write      = 1'b1;
        mem_address    = {r_tag[r_way][r_idx], r_idx};
        mem_WRITE_DATA = r_data[r_way][r_idx];
        if (!mem_busywait) w_next = S_FETCH;
      end
      S_FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {r_ltag, r_idx};
        if (!mem_busywait) w_next = S_REFILL;
      end
      S_REFILL: begin
        busywait = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_ltag  <= w_tag;
        r_idx   <= w_idx;
        r_off   <= w_off;
        r_way   <= w_vic;
        r_wr    <= WRITE_EN;
        r_wdata <= WRITE_DATA;
        r_be    <= BYTE_EN;
      end
      if (w_hit && WRITE_EN && |BYTE_EN)
        r_dirty[w_hway][w_idx] <= 1'b1;
      if (w_refill) begin
        r_valid[r_way][r_idx] <= 1'b1;
        r_dirty[r_way][r_idx] <= r_wr;
      end
    end
  end

  always_ff @(negedge CLOCK) begin
    if (!RESET) begin
      if (w_hit && WRITE_EN)
        r_data[w_hway][w_idx][int'(w_off)*32 +: 32] <= byte_merge(
          r_data[w_hway][w_idx][int'(w_off)*32 +: 32], WRITE_DATA, BYTE_EN);
      if (w_refill) begin
        r_tag[r_way][r_idx]  <= r_ltag;
        r_data[r_way][r_idx] <= w_fill;
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed and random checks of dcache_assoc against a
// flat-memory / timestamp-LRU reference model with a 5-cycle block memory.
module tb_dcache_assoc;
  localparam int LAT = 5;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         READ_EN = 1'b0;
  logic         WRITE_EN = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  WRITE_DATA = '0;
  logic [3:0]   BYTE_EN = '0;
  logic [31:0]  READ_DATA;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_WRITE_DATA;
  logic [127:0] mem_READ_DATA = '0;
  logic         mem_busywait = 1'b0;

  dcache_assoc #(.WAYS(2), .SETS(8), .WORDS(4)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .READ_EN        (READ_EN),
    .WRITE_EN       (WRITE_EN),
    .address        (address),
    .WRITE_DATA     (WRITE_DATA),
    .BYTE_EN        (BYTE_EN),
    .READ_DATA      (READ_DATA),
    .busywait       (busywait),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_WRITE_DATA (mem_WRITE_DATA),
    .mem_READ_DATA  (mem_READ_DATA),
    .mem_busywait   (mem_busywait)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Backing memory seen by the DUT, and the architectural view of memory.
  bit [31:0] memw [int];
  bit [31:0] gold [int];

  function automatic bit [31:0] defw(int wa);
    return (wa * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction
  function automatic bit [31:0] mv(int wa);
    return memw.exists(wa) ? memw[wa] : defw(wa);
  endfunction
  function automatic bit [31:0] gv(int wa);
    return gold.exists(wa) ? gold[wa] : defw(wa);
  endfunction

  logic [27:0] exp_fe_ma = '0;
  logic [27:0] exp_wb_ma = '0;
  int          mcnt = 0;

  // Block memory: each request completes LAT cycles after it first appears.
  always @(posedge CLOCK) begin
    if (!(mem_read || mem_write)) begin
      mcnt = 0;
      mem_busywait = 1'b0;
    end else begin
      chk("rw_excl", mem_read & mem_write, 1'b0);
      mcnt++;
      if (mcnt >= LAT) begin
        int base;
        logic [127:0] blk;
        base = int'(mem_address) * 4;
        if (mem_write) begin
          chk("wb_addr", mem_address, exp_wb_ma);
          for (int i = 0; i < 4; i++) blk[32*i +: 32] = gv(base + i);
          chk("wb_data", mem_WRITE_DATA, blk);
          for (int i = 0; i < 4; i++)
            memw[base + i] = mem_WRITE_DATA[32*i +: 32];
        end else begin
          chk("fe_addr", mem_address, exp_fe_ma);
          for (int i = 0; i < 4; i++) blk[32*i +: 32] = mv(base + i);
          mem_READ_DATA = blk;
        end
        mcnt = 0;
        mem_busywait = 1'b0;
      end else begin
        mem_busywait = 1'b1;
      end
    end
  end

  // Cache model: per-line valid/dirty/tag and a last-use timestamp.
  bit m_v [8][2];
  bit m_d [8][2];
  int m_t [8][2];
  int m_s [8][2];
  int tick = 0;

  task automatic model_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
        m_s[s][w] = -w;
      end
    tick = 0;
  endtask

  task automatic predict(input logic [31:0] a, output bit hit,
                         output int way, output int exp);
    int s, t;
    s = int'(a[6:4]);
    t = int'(a[31:7]);
    hit = 1'b0;
    way = -1;
    for (int w = 0; w < 2; w++)
      if (m_v[s][w] && m_t[s][w] == t) begin
        hit = 1'b1;
        way = w;
      end
    if (hit) begin
      exp = 0;
    end else begin
      for (int w = 0; w < 2; w++)
        if (!m_v[s][w] && way < 0) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < 2; w++)
          if (m_s[s][w] < m_s[s][way]) way = w;
      end
      exp_fe_ma = a[31:4];
      if (m_v[s][way] && m_d[s][way]) begin
        exp = 2 * LAT + 2;
        exp_wb_ma = 28'((m_t[s][way] << 3) | s);
      end else begin
        exp = LAT + 2;
      end
    end
  endtask

  task automatic commit(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit hit, input int way);
    int s, wa;
    bit [31:0] old;
    s = int'(a[6:4]);
    if (!hit) begin
      m_v[s][way] = 1'b1;
      m_t[s][way] = int'(a[31:7]);
      m_d[s][way] = wr;
    end
    tick++;
    m_s[s][way] = tick;
    if (wr) begin
      wa = int'(a[31:2]);
      old = gv(wa);
      for (int b = 0; b < 4; b++)
        if (be[b]) old[8*b +: 8] = d[8*b +: 8];
      gold[wa] = old;
      if (be != 4'd0) m_d[s][way] = 1'b1;
    end
  endtask

  // One CPU request, driven just after a falling edge, held until it hits.
  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit both);
    bit hit;
    int way, exp, stall;
    predict(a, hit, way, exp);
    WRITE_EN = wr;
    READ_EN = !wr | both;
    address = a;
    WRITE_DATA = d;
    BYTE_EN = be;
    stall = 0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (!busywait || stall > 60) break;
      stall++;
    end
    chk($sformatf("stall@%0h", a), stall, exp);
    if (!wr)
      chk($sformatf("rdata@%0h", a), READ_DATA, gv(int'(a[31:2])));
    @(negedge CLOCK);
    #1;
    READ_EN = 1'b0;
    WRITE_EN = 1'b0;
    commit(wr, a, d, be, hit, way);
  endtask

  task automatic wait_mem_read();
    int n;
    n = 0;
    do begin
      @(posedge CLOCK);
      #1;
      n++;
    end while (!mem_read && n < 50);
    chk("mrd_up", mem_read, 1'b1);
  endtask

  initial begin
    bit hit;
    int way, exp, n;
    logic [31:0] a;

    model_reset();
    repeat (2) @(negedge CLOCK);
    #1;
    RESET = 1'b0;
    @(posedge CLOCK);
    #1;
    chk("rst_busy", busywait, 1'b0);
    chk("rst_mrd", mem_read, 1'b0);
    chk("rst_mwr", mem_write, 1'b0);
    chk("rst_ma", mem_address, 28'd0);
    chk("rst_mwd", mem_WRITE_DATA, 128'd0);
    chk("rst_rd", READ_DATA, 32'd0);
    @(negedge CLOCK);
    #1;

    // Cold read miss, then partial store hit and read-back.
    access(0, 32'h0000_0040, 0, 0, 0);
    access(1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0011, 0);
    access(0, 32'h0000_0044, 0, 0, 0);
    access(1, 32'h0000_0048, 32'h1234_5678, 4'b0000, 1);

    // Set 4: A, B, touch A, C replaces B, A still hits.
    access(0, 32'h0000_00C0, 0, 0, 0);
    access(0, 32'h0000_0140, 0, 0, 0);
    access(0, 32'h0000_00C4, 0, 0, 0);
    access(0, 32'h0000_01C8, 0, 0, 0);
    access(0, 32'h0000_00CC, 0, 0, 0);
    access(0, 32'h0000_0140, 0, 0, 0);

    // Dirty A is evicted with a write-back.
    access(1, 32'h0000_00C8, 32'hDEAD_BEEF, 4'b1111, 0);
    access(0, 32'h0000_01C0, 0, 0, 0);
    access(0, 32'h0000_0240, 0, 0, 0);
    access(0, 32'h0000_00C8, 0, 0, 0);

    // Write miss allocates and merges.
    access(1, 32'h0000_0328, 32'h0BAD_F00D, 4'b1111, 0);
    access(0, 32'h0000_0328, 0, 0, 0);
    access(0, 32'h0000_0320, 0, 0, 0);

    // Request withdrawn and address changed while the miss is in flight.
    a = 32'h0000_0A30;
    predict(a, hit, way, exp);
    READ_EN = 1'b1;
    address = a;
    wait_mem_read();
    READ_EN = 1'b0;
    address = 32'h0000_0130;
    n = 0;
    do begin
      @(posedge CLOCK);
      #1;
      n++;
    end while ((busywait || mem_read || mem_write) && n < 50);
    chk("idle_back", busywait, 1'b0);
    commit(0, a, 0, 0, hit, way);
    @(negedge CLOCK);
    #1;
    access(0, 32'h0000_0A34, 0, 0, 0);

    // Reset during FETCH drops the request and invalidates every line.
    a = 32'h0000_0B50;
    predict(a, hit, way, exp);
    READ_EN = 1'b1;
    address = a;
    wait_mem_read();
    RESET = 1'b1;
    READ_EN = 1'b0;
    @(negedge CLOCK);
    #1;
    chk("rstm_mrd", mem_read, 1'b0);
    chk("rstm_busy", busywait, 1'b0);
    chk("rstm_mwr", mem_write, 1'b0);
    RESET = 1'b0;
    model_reset();
    gold = memw;
    access(0, a, 0, 0, 0);
    access(0, 32'h0000_0040, 0, 0, 0);

    // Random traffic over a few conflicting tags.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = (32'($urandom_range(1, 5)) << 7) |
           (32'($urandom_range(0, 7)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom_range(0, 1)), ra, $urandom,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
